// File: rtl/nn_mac_engine.sv
// Multi-lane signed multiply-accumulate neuron engine: per-lane accumulation over a
// programmable vector length, then lane aggregation, shift, optional ReLU and saturation.
module nn_mac_engine #(
  parameter int unsigned DW      = 8,
  parameter int unsigned N_LANES = 4,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned SH_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [SH_W-1:0]         shift,
  input  logic                    relu_en,
  input  logic [N_LANES*DW-1:0]   in_a,
  input  logic [N_LANES*DW-1:0]   in_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DW-1:0]           out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned LG_LANES = $clog2(N_LANES);
  localparam int unsigned SUM_W    = ACC_W + LG_LANES;
  localparam int unsigned PW       = 2 * DW;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    AGG   = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic [LEN_W-1:0] vlen;
    logic [SH_W-1:0]  sh;
    logic             relu;
  } cfg_t;

  state_t state, state_nx;
  cfg_t   cfg;

  logic in_ready_nx, out_valid_nx, busy_nx;
  logic cap_cfg, acc_en, res_ld;
  logic beat;

  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        last_cnt;
  logic signed [ACC_W-1:0] acc      [N_LANES];
  logic signed [ACC_W-1:0] prod_ext [N_LANES];
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] res;
  logic [DW-1:0]           res_sat;

  assign beat     = in_valid & in_ready;
  assign last_cnt = cfg.vlen - LEN_W'(1);
  assign done     = out_valid & out_ready;

  // Per-lane full-precision signed product, sign-extended to accumulator width
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] b_s;
    logic signed [PW-1:0] p;
    assign a_s         = in_a[g*DW +: DW];
    assign b_s         = in_b[g*DW +: DW];
    assign p           = a_s * b_s;
    assign prod_ext[g] = ACC_W'(p);
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      busy      <= busy_nx;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nx = state;
    cap_cfg  = 1'b0;
    acc_en   = 1'b0;
    res_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap_cfg  = 1'b1;
          state_nx = (len != '0) ? ACCUM : AGG;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_en = 1'b1;
          if (cnt == last_cnt) state_nx = AGG;
        end
      end
      AGG: begin
        res_ld   = 1'b1;
        state_nx = OUT;
      end
      OUT: begin
        if (out_valid && out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx  = (state_nx == ACCUM);
    out_valid_nx = (state_nx == OUT);
    busy_nx      = (state_nx != IDLE);
  end

  // Aggregate, arithmetic shift, optional rectify, saturate to DW
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      sum = sum + SUM_W'(acc[i]);
    end
    res = sum >>> cfg.sh;
    if (cfg.relu && res[SUM_W-1]) res = '0;
    if (res > SAT_MAX)      res_sat = DW'(SAT_MAX);
    else if (res < SAT_MIN) res_sat = DW'(SAT_MIN);
    else                    res_sat = DW'(res);
  end

  // Config capture, beat counter, accumulators and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg      <= '0;
      cnt      <= '0;
      out_data <= '0;
      for (int unsigned i = 0; i < N_LANES; i++) acc[i] <= '0;
    end else begin
      if (cap_cfg) begin
        cfg.vlen <= len;
        cfg.sh   <= shift;
        cfg.relu <= relu_en;
        cnt      <= '0;
        for (int unsigned i = 0; i < N_LANES; i++) acc[i] <= '0;
      end else if (acc_en) begin
        cnt <= cnt + LEN_W'(1);
        for (int unsigned i = 0; i < N_LANES; i++) acc[i] <= acc[i] + prod_ext[i];
      end
      if (res_ld) out_data <= res_sat;
    end
  end

endmodule

// File: tb/tb_nn_mac_engine.sv
// Directed self-checking bench for nn_mac_engine (DW=8, N_LANES=4).
module tb_nn_mac_engine;

  localparam int unsigned DW      = 8;
  localparam int unsigned N_LANES = 4;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SH_W    = 5;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [LEN_W-1:0]      len;
  logic [SH_W-1:0]       shift;
  logic                  relu_en;
  logic [N_LANES*DW-1:0] in_a;
  logic [N_LANES*DW-1:0] in_b;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  nn_mac_engine #(.DW(DW), .N_LANES(N_LANES), .ACC_W(24), .LEN_W(LEN_W), .SH_W(SH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .shift(shift), .relu_en(relu_en),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N_LANES*DW-1:0] rep(input logic [DW-1:0] v);
    return {N_LANES{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a job in the current cycle with steady input/output streams and check result + latency
  task automatic run_simple(input string tag, input logic [LEN_W-1:0] l, input logic [SH_W-1:0] sh,
                            input logic relu, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] exp);
    int n;
    start = 1'b1; len = l; shift = sh; relu_en = relu;
    in_a = rep(a); in_b = rep(b); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    chk({tag, "_lat"}, 32'(n), 32'(l) + 32'd2);
    chk({tag, "_done"}, 32'(done), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_idle"}, 32'({busy, out_valid, done}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; shift = '0; relu_en = 1'b0;
    in_a = '0; in_b = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_outs", 32'({in_ready, out_valid, busy, done}), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst = 1'b1;
    tick();

    // Basic: len=2, a=3, b=2 on all lanes -> 48, out_valid at cycle 4
    start = 1'b1; len = 8'd2; shift = '0; relu_en = 1'b0;
    in_a = rep(8'd3); in_b = rep(8'd2); in_valid = 1'b1; out_ready = 1'b1;
    tick();  // cycle 1
    start = 1'b0;
    chk("c1_in_ready", 32'(in_ready), 32'd1);
    chk("c1_busy", 32'(busy), 32'd1);
    tick();  // cycle 2
    chk("c2_in_ready", 32'(in_ready), 32'd1);
    tick();  // cycle 3 (AGG)
    chk("c3_in_ready", 32'(in_ready), 32'd0);
    chk("c3_out_valid", 32'(out_valid), 32'd0);
    tick();  // cycle 4
    chk("c4_out_valid", 32'(out_valid), 32'd1);
    chk("c4_out_data", 32'(out_data), 32'd48);
    chk("c4_done", 32'(done), 32'd1);
    tick();  // cycle 5: back-to-back start follows in run_simple
    chk("c5_done", 32'(done), 32'd0);
    chk("c5_out_valid", 32'(out_valid), 32'd0);

    run_simple("neg", 8'd1, 5'd0, 1'b0, 8'hFB, 8'd4, 8'hB0);
    run_simple("relu", 8'd1, 5'd0, 1'b1, 8'hFB, 8'd4, 8'h00);
    run_simple("satp", 8'd1, 5'd0, 1'b0, 8'd127, 8'd127, 8'd127);
    run_simple("sh10", 8'd1, 5'd10, 1'b0, 8'd127, 8'd127, 8'd63);
    run_simple("satn", 8'd1, 5'd0, 1'b0, 8'h80, 8'd127, 8'h80);

    // Gapped input, ignored starts while busy, back-pressured output
    start = 1'b1; len = 8'd3; shift = '0; relu_en = 1'b0;
    in_a = rep(8'd1); in_b = rep(8'd1); in_valid = 1'b1; out_ready = 1'b0;
    tick();  // cycle 1: beat 1
    start = 1'b0;
    tick();  // cycle 2: gap, plus a stray start that must be ignored
    in_valid = 1'b0; in_a = rep(8'd50); in_b = rep(8'd50);
    start = 1'b1; len = 8'd1; shift = 5'd3;
    tick();  // cycle 3: gap
    start = 1'b0;
    chk("gap_in_ready", 32'(in_ready), 32'd1);
    tick();  // cycle 4: beat 2
    in_valid = 1'b1; in_a = rep(8'd1); in_b = rep(8'd1);
    tick();  // cycle 5: gap
    in_valid = 1'b0; in_a = rep(8'd50); in_b = rep(8'd50);
    tick();  // cycle 6: beat 3
    in_valid = 1'b1; in_a = rep(8'd1); in_b = rep(8'd1);
    tick();  // cycle 7: AGG; extra valid data must not count
    in_a = rep(8'd50); in_b = rep(8'd50);
    chk("gap_ready_drop", 32'(in_ready), 32'd0);
    chk("gap_agg_valid", 32'(out_valid), 32'd0);
    tick();  // cycle 8: OUT, stalled
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'd12);
      chk("stall_done", 32'(done), 32'd0);
      if (i == 2) begin
        start = 1'b1; len = 8'd1; shift = 5'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("hs_done", 32'(done), 32'd1);
    chk("hs_data", 32'(out_data), 32'd12);
    tick();
    chk("hs_after", 32'({out_valid, done, busy}), 32'd0);

    // Reset mid-accumulation after 2 of 4 beats
    start = 1'b1; len = 8'd4; shift = '0; relu_en = 1'b0;
    in_a = rep(8'd10); in_b = rep(8'd10); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("arst_outs", 32'({in_ready, out_valid, busy, done}), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    #2;
    rst = 1'b1;
    tick();
    run_simple("post_rst", 8'd1, 5'd0, 1'b0, 8'd1, 8'd1, 8'd4);

    // Zero length: straight to aggregation, result 0
    start = 1'b1; len = 8'd0; shift = '0; relu_en = 1'b0;
    in_a = rep(8'd5); in_b = rep(8'd5); in_valid = 1'b1; out_ready = 1'b1;
    tick();  // cycle 1
    start = 1'b0;
    chk("z_c1_ready", 32'(in_ready), 32'd0);
    chk("z_c1_busy", 32'(busy), 32'd1);
    tick();  // cycle 2
    chk("z_c2_ready", 32'(in_ready), 32'd0);
    chk("z_c2_valid", 32'(out_valid), 32'd1);
    chk("z_c2_data", 32'(out_data), 32'd0);
    chk("z_c2_done", 32'(done), 32'd1);
    tick();
    chk("z_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_mac_engine.md
Name: nn_mac_engine

Overview:
- Parametrised multi-lane multiply-accumulate neuron engine. It is the next-generation ALU/aggregator datapath of the NN accelerator.
- Each of N_LANES lanes multiplies signed activation/weight pairs streamed from the memories and accumulates them over a programmable vector length.
- Lane sums are then aggregated, scaled, optionally rectified, saturated, and handed to the output buffer over a valid/ready handshake.

Parameters:
- DW, 8: signed activation/weight/output width.
- N_LANES, 4: parallel MAC lanes. Power of two, from 1 to 16.
- ACC_W, 24: signed per-lane accumulator width. Must be at least 2*DW + log2(MAX_LEN).
- LEN_W, 8: width of the vector length field. Maximum length is 2^LEN_W - 1.
- SH_W, 5: width of the output right-shift field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a neuron computation; sampled in IDLE only.
- len  in  LEN_W  number of input beats; captured on start.
- shift  in  SH_W  arithmetic right shift on the aggregate; captured on start.
- relu_en  in  1  clamp negative results to 0; captured on start.
- in_a  in  N_LANES*DW  packed signed activations, lane 0 in the LSBs.
- in_b  in  N_LANES*DW  packed signed weights, lane 0 in the LSBs.
- in_valid  in  1  in_a/in_b beat valid.
- in_ready  out  1  engine accepts a beat.
- out_data  out  DW  signed result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the output handshake.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - in_ready, out_valid, busy, done = 0; out_data = 0.
  - Accumulators, beat counter and captured config cleared.
  - Reset mid-operation abandons the computation with no output.
- IDLE:
  - on start=1: capture len/shift/relu_en, clear accumulators and beat counter.
  - go to ACCUM if len!=0, else go to AGG (the result is then 0 before shift/ReLU).
- ACCUM:
  - in_ready=1 (registered, asserted the cycle after start).
  - Each cycle with in_valid&in_ready: acc[i] += sext(a[i]*b[i]) for every lane, and the counter increments.
  - When the counter reaches len-1 on an accepted beat, go to AGG. in_ready drops in that same transition.
  - in_valid gaps stall with no state change.
  - start is ignored outside IDLE.
- AGG (1 cycle):
  - sum = sign-extended sum of all lanes, width ACC_W+log2(N_LANES).
  - res = sum >>> shift (arithmetic).
  - If relu_en and res<0, res=0.
  - Saturate res to [-2^(DW-1), 2^(DW-1)-1].
  - Register the result into out_data and go to OUT.
- OUT:
  - out_valid=1; out_data is held stable until out_ready=1.
  - On out_valid&out_ready: done=1 for that cycle only, out_valid drops next cycle, go to IDLE.
  - out_ready asserted before out_valid has no effect.
- Arithmetic:
  - Products are full 2*DW signed.
  - Accumulators wrap modulo 2^ACC_W; sizing by ACC_W prevents overflow for legal len.
  - Saturation is applied only at output.
- Latency, with in_valid and out_ready held high:
  - start at cycle 0; first beat accepted cycle 1; last beat at cycle len.
  - AGG at cycle len+1; out_valid at cycle len+2; done at cycle len+2.
  - Back-to-back start is accepted the cycle after done.
- busy=1 from the cycle after start accepted through the done cycle.

Test Plan:
- DW=8, N_LANES=4, len=2, shift=0, relu_en=0; every lane a=3, b=2 both beats.
  - Required: each lane 12, aggregate 48, out_data=48.
  - Required timing: out_valid at cycle 4, done pulse 1 cycle.
- len=1, a=-5, b=4 all lanes (aggregate -80).
  - relu_en=0: out_data=-80 (0xB0).
  - relu_en=1: out_data=0.
- len=1, a=127, b=127 all lanes (aggregate 64516).
  - shift=0: out_data saturates to 127.
  - shift=10: out_data=63.
  - a=-128, b=127, shift=0: out_data=-128.
- len=3, in_valid toggled 1,0,0,1,0,1; out_ready held 0 for 5 cycles after out_valid.
  - Required: exactly 3 beats accumulated; in_ready=0 after the third beat.
  - Required: out_data stable and out_valid held while out_ready=0; done only on the handshake cycle.
- rst pulsed low during ACCUM after 2 of 4 beats.
  - Required: all outputs 0 immediately.
  - Required: a new start with len=1, a=1, b=1 yields out_data=4 with no residue from the aborted run.
- start with len=0.
  - Required: in_ready never asserts; out_valid at cycle 2 with out_data=0.
- start pulsed while busy: ignored, and the captured len/shift are unchanged.
